// File: rtl/fpmul_pkg.sv
// Shared types and helpers for the FP32 multiplier issuer.
// Provides the default datapath width, the FP32 word type, the operand-pair
// record, and the counter width helper. A counter sized by cnt_w can hold
// every value from 0 to depth inclusive.
package fpmul_pkg;

  localparam int FP32_W = 32;

  typedef logic [31:0] fp32_t;

  typedef struct packed {
    fp32_t a;
    fp32_t b;
  } operand_pair_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpmul_issuer_chk.sv
// fpmul_issuer_chk: runtime checks on the issuer's flow-control bookkeeping.
// Ports: clk, rst_n, plus observation-only copies of the credit counter,
// outstanding counter, result FIFO occupancy/full, issue-valid, load strobe,
// result push strobe and operand FIFO occupancy. Drives nothing.
module fpmul_issuer_chk #(
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4,
  parameter int CW        = 3,
  parameter int OCW       = 3
) (
  input logic           clk,
  input logic           rst_n,
  input logic [CW-1:0]  credits_i,
  input logic [CW-1:0]  outstanding_i,
  input logic [CW-1:0]  res_count_i,
  input logic           res_full_i,
  input logic           fpu_valid_i,
  input logic           load_i,
  input logic           res_push_i,
  input logic [OCW-1:0] op_count_i
);

  // Every slot is exactly one of: free credit, in issue reg, in flight, buffered
  a_slot_invariant: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(credits_i) + int'(outstanding_i) + int'(res_count_i) + (fpu_valid_i ? 1 : 0)) == RES_DEPTH);

  a_credit_max: assert property (@(posedge clk) disable iff (!rst_n)
    int'(credits_i) <= RES_DEPTH);

  a_credit_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    load_i |-> (credits_i != CW'(0)));

  a_res_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    res_push_i |-> !res_full_i);

  a_op_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    int'(op_count_i) <= OP_DEPTH);

endmodule

// File: rtl/fpmul_issuer_sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push_i, wdata_i       write strobe and data (ignored while full)
//   pop_i                 read strobe (ignored while empty)
//   rdata_o               head entry, valid whenever empty_o is low
//   full_o, empty_o       status derived from the registered count
//   count_o               number of stored entries
// Storage is cleared on reset so the head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == (AW+1)'(0));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next-state for pointers and occupancy; pointers wrap since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fpmul_issuer.sv
// fpmul_issuer: operand-side requester for the FP32 multiplier.
// Ports:
//   clk, rst (async active-low)
//   op_valid/op_a/op_b/op_ready        upstream operand pairs (valid/ready)
//   fpu_A/fpu_B/fpu_valid/fpu_ready    registered issue port to the multiplier
//   fpu_res_valid/fpu_data             multiplier result stream (no back-pressure)
//   res_valid/res_data/res_ready       buffered results to downstream
//   outstanding                        issued-but-not-returned count
//   err_spurious                       sticky: result arrived with nothing outstanding
// A credit is consumed when an operand pair is loaded into the issue register
// and returned when its result leaves the result FIFO, so the result FIFO
// always has room for every multiplication in flight.
module fpmul_issuer
  import fpmul_pkg::*;
#(
  parameter int DATA_W    = FP32_W,
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_valid,
  input  logic [DATA_W-1:0]             op_a,
  input  logic [DATA_W-1:0]             op_b,
  output logic                          op_ready,
  output logic [DATA_W-1:0]             fpu_A,
  output logic [DATA_W-1:0]             fpu_B,
  output logic                          fpu_valid,
  input  logic                          fpu_ready,
  input  logic                          fpu_res_valid,
  input  logic [DATA_W-1:0]             fpu_data,
  output logic                          res_valid,
  output logic [DATA_W-1:0]             res_data,
  input  logic                          res_ready,
  output logic [$clog2(RES_DEPTH):0]    outstanding,
  output logic                          err_spurious
);

  localparam int CW  = cnt_w(RES_DEPTH);
  localparam int OCW = cnt_w(OP_DEPTH);

  logic [2*DATA_W-1:0] op_head_s;
  logic                op_full_s;
  logic                op_empty_s;
  logic [OCW-1:0]      op_count_s;
  logic                op_push_s;
  logic                res_full_s;
  logic                res_empty_s;
  logic [CW-1:0]       res_count_s;
  logic                res_push_s;
  logic                res_pop_s;
  logic                load_s;
  logic                fpu_hs_s;
  logic                spur_s;

  logic [DATA_W-1:0]   fpu_a_q;
  logic [DATA_W-1:0]   fpu_a_d;
  logic [DATA_W-1:0]   fpu_b_q;
  logic [DATA_W-1:0]   fpu_b_d;
  logic                fpu_valid_q;
  logic                fpu_valid_d;
  logic [CW-1:0]       credits_q;
  logic [CW-1:0]       credits_d;
  logic [CW-1:0]       outstanding_q;
  logic [CW-1:0]       outstanding_d;
  logic                err_q;
  logic                err_d;

  assign op_ready  = !op_full_s;
  assign op_push_s = op_valid && !op_full_s;

  sync_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (OP_DEPTH)
  ) u_op_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (op_push_s),
    .wdata_i ({op_a, op_b}),
    .pop_i   (load_s),
    .rdata_o (op_head_s),
    .full_o  (op_full_s),
    .empty_o (op_empty_s),
    .count_o (op_count_s)
  );

  // The issue register may refill whenever its current content leaves this cycle
  assign fpu_hs_s   = fpu_valid_q && fpu_ready;
  assign load_s     = !op_empty_s && (credits_q != CW'(0)) && (!fpu_valid_q || fpu_ready);
  assign res_push_s = fpu_res_valid && (outstanding_q != CW'(0));
  assign spur_s     = fpu_res_valid && (outstanding_q == CW'(0));
  assign res_pop_s  = res_ready && !res_empty_s;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (res_push_s),
    .wdata_i (fpu_data),
    .pop_i   (res_pop_s),
    .rdata_o (res_data),
    .full_o  (res_full_s),
    .empty_o (res_empty_s),
    .count_o (res_count_s)
  );

  // Issue register next state: load head, drop valid after an unreplaced handshake, else hold
  always_comb begin
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_valid_d = fpu_valid_q;
    if (load_s) begin
      fpu_a_d     = op_head_s[2*DATA_W-1:DATA_W];
      fpu_b_d     = op_head_s[DATA_W-1:0];
      fpu_valid_d = 1'b1;
    end else if (fpu_hs_s) begin
      fpu_valid_d = 1'b0;
    end else begin
      fpu_valid_d = fpu_valid_q;
    end
  end

  // Credit, outstanding and error next state
  always_comb begin
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    err_d         = err_q | spur_s;
    if (load_s && !res_pop_s) begin
      credits_d = credits_q - CW'(1);
    end else if (!load_s && res_pop_s) begin
      credits_d = credits_q + CW'(1);
    end else begin
      credits_d = credits_q;
    end
    if (fpu_hs_s && !res_push_s) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!fpu_hs_s && res_push_s) begin
      outstanding_d = outstanding_q - CW'(1);
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_a_q       <= {DATA_W{1'b0}};
      fpu_b_q       <= {DATA_W{1'b0}};
      fpu_valid_q   <= 1'b0;
      credits_q     <= CW'(RES_DEPTH);
      outstanding_q <= CW'(0);
      err_q         <= 1'b0;
    end else begin
      fpu_a_q       <= fpu_a_d;
      fpu_b_q       <= fpu_b_d;
      fpu_valid_q   <= fpu_valid_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign fpu_A        = fpu_a_q;
  assign fpu_B        = fpu_b_q;
  assign fpu_valid    = fpu_valid_q;
  assign res_valid    = !res_empty_s;
  assign outstanding  = outstanding_q;
  assign err_spurious = err_q;

  fpmul_issuer_chk #(
    .OP_DEPTH  (OP_DEPTH),
    .RES_DEPTH (RES_DEPTH),
    .CW        (CW),
    .OCW       (OCW)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst),
    .credits_i     (credits_q),
    .outstanding_i (outstanding_q),
    .res_count_i   (res_count_s),
    .res_full_i    (res_full_s),
    .fpu_valid_i   (fpu_valid_q),
    .load_i        (load_s),
    .res_push_i    (res_push_s),
    .op_count_i    (op_count_s)
  );

endmodule

// File: tb/tb_fpmul_issuer.sv
// Self-checking bench for fpmul_issuer: a latency-configurable multiplier
// model answers from a table of hand-computed FP32 products; expected results
// are queued at operand handshake and compared by a separate monitor.
module tb_fpmul_issuer;
  import fpmul_pkg::*;

  localparam int RESD = 4;
  localparam int CW   = $clog2(RESD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  fp32_t         op_a = 32'h0;
  fp32_t         op_b = 32'h0;
  logic          op_ready;
  fp32_t         fpu_A;
  fp32_t         fpu_B;
  logic          fpu_valid;
  logic          fpu_ready = 1'b0;
  logic          fpu_res_valid;
  fp32_t         fpu_data;
  logic          res_valid;
  fp32_t         res_data;
  logic          res_ready = 1'b0;
  logic [CW-1:0] outstanding;
  logic          err_spurious;

  fpmul_issuer #(.DATA_W(32), .OP_DEPTH(4), .RES_DEPTH(RESD)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_ready      (op_ready),
    .fpu_A         (fpu_A),
    .fpu_B         (fpu_B),
    .fpu_valid     (fpu_valid),
    .fpu_ready     (fpu_ready),
    .fpu_res_valid (fpu_res_valid),
    .fpu_data      (fpu_data),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .outstanding   (outstanding),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;

  // Hand-computed FP32 products
  operand_pair_t vec_op [8];
  fp32_t         vec_p  [8];

  function automatic fp32_t prod(input fp32_t a, input fp32_t b);
    fp32_t r;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) begin
      if (vec_op[i].a == a && vec_op[i].b == b) r = vec_p[i];
    end
    return r;
  endfunction

  // Multiplier model: in-order pipeline, result taken from stage lat-1
  logic [2:0] m_v;
  fp32_t      m_d [3];
  int         lat = 3;
  logic       spur_v = 1'b0;
  fp32_t      spur_d = 32'h0;
  int         hs_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v <= 3'b000;
      for (int i = 0; i < 3; i++) m_d[i] <= 32'h0;
    end else begin
      m_v    <= {m_v[1:0], fpu_valid && fpu_ready};
      m_d[0] <= prod(fpu_A, fpu_B);
      m_d[1] <= m_d[0];
      m_d[2] <= m_d[1];
      if (fpu_valid && fpu_ready) hs_cnt <= hs_cnt + 1;
    end
  end

  assign fpu_res_valid = spur_v | m_v[lat-1];
  assign fpu_data      = spur_v ? spur_d : m_d[lat-1];

  // Scoreboard and counters
  int    checks = 0;
  int    failures = 0;
  fp32_t sb_q [$];
  int    pop_cnt = 0;
  logic  stall_en = 1'b0;
  logic  prev_stall = 1'b0;
  fp32_t prev_a = 32'h0;
  fp32_t prev_b = 32'h0;
  fp32_t exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: result pops against the scoreboard, and issue-port stability under stall
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      pop_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL res_unexpected actual=%h required=none", res_data);
      end else begin
        exp_v = sb_q.pop_front();
        check("res_data", res_data, exp_v);
      end
    end
    if (rst && stall_en && prev_stall) begin
      check("stall_valid", 32'(fpu_valid), 32'h1);
      check("stall_A", fpu_A, prev_a);
      check("stall_B", fpu_B, prev_b);
    end
    prev_stall = fpu_valid && !fpu_ready;
    prev_a     = fpu_A;
    prev_b     = fpu_B;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input int idx);
    int n;
    n = 0;
    op_a = vec_op[idx].a;
    op_b = vec_op[idx].b;
    op_valid = 1'b1;
    while (!op_ready && n < 50) begin
      tick();
      n++;
    end
    if (!op_ready) begin
      op_valid = 1'b0;
      checks++;
      failures++;
      $display("FAIL push_timeout actual=op_ready_low required=op_ready_high");
    end else begin
      sb_q.push_back(vec_p[idx]);
      tick();
      op_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_ready"}, 32'(op_ready), 32'h1);
    check({tag, "_fpu_valid"}, 32'(fpu_valid), 32'h0);
    check({tag, "_fpu_A"}, fpu_A, 32'h0);
    check({tag, "_fpu_B"}, fpu_B, 32'h0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'h0);
    check({tag, "_res_data"}, res_data, 32'h0);
    check({tag, "_outstanding"}, 32'(outstanding), 32'h0);
    check({tag, "_err"}, 32'(err_spurious), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int n;
    int p0;
    int p1;
    bit [3:0] pat;

    vec_op[0] = '{a: 32'h3F800000, b: 32'h40000000}; vec_p[0] = 32'h40000000; // 1*2=2
    vec_op[1] = '{a: 32'h40400000, b: 32'h40800000}; vec_p[1] = 32'h41400000; // 3*4=12
    vec_op[2] = '{a: 32'h40000000, b: 32'h40000000}; vec_p[2] = 32'h40800000; // 2*2=4
    vec_op[3] = '{a: 32'h3FC00000, b: 32'h40000000}; vec_p[3] = 32'h40400000; // 1.5*2=3
    vec_op[4] = '{a: 32'h3F000000, b: 32'h3F000000}; vec_p[4] = 32'h3E800000; // .5*.5=.25
    vec_op[5] = '{a: 32'hBF800000, b: 32'h40000000}; vec_p[5] = 32'hC0000000; // -1*2=-2
    vec_op[6] = '{a: 32'h41200000, b: 32'h41200000}; vec_p[6] = 32'h42C80000; // 10*10=100
    vec_op[7] = '{a: 32'h40200000, b: 32'h40000000}; vec_p[7] = 32'h40A00000; // 2.5*2=5

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b1;
    tick();

    // Test 1: single op, latency 3
    lat = 3;
    fpu_ready = 1'b1;
    res_ready = 1'b1;
    push_op(0);
    check("t1_valid_after_hs", 32'(fpu_valid), 32'h0);
    tick();
    check("t1_valid_next", 32'(fpu_valid), 32'h1);
    check("t1_fpu_A", fpu_A, 32'h3F800000);
    check("t1_fpu_B", fpu_B, 32'h40000000);
    n = 0;
    while (!fpu_res_valid && n < 20) begin
      tick();
      n++;
    end
    check("t1_fpu_res_seen", 32'(fpu_res_valid), 32'h1);
    tick();
    check("t1_res_valid", 32'(res_valid), 32'h1);
    check("t1_res_data", res_data, 32'h40000000);
    check("t1_outstanding", 32'(outstanding), 32'h0);
    tick();
    check("t1_res_gone", 32'(res_valid), 32'h0);

    // Test 2: credit limit with downstream stalled
    res_ready = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 6; i++) push_op(i);
    repeat (15) tick();
    check("t2_handshakes", 32'(hs_cnt - hs0), 32'h4);
    check("t2_op_count", 32'(dut.u_op_fifo.count_o), 32'h2);
    check("t2_res_valid", 32'(res_valid), 32'h1);
    check("t2_res_count", 32'(dut.u_res_fifo.count_o), 32'h4);
    check("t2_outstanding", 32'(outstanding), 32'h0);
    check("t2_fpu_valid", 32'(fpu_valid), 32'h0);
    res_ready = 1'b1;
    wait_drain();
    check("t2_handshakes_all", 32'(hs_cnt - hs0), 32'h6);

    // Test 3: fpu_ready toggling 1,0,0,1 during a burst
    pat = 4'b1001;
    hs0 = hs_cnt;
    stall_en = 1'b1;
    fork
      begin
        for (int i = 1; i < 5; i++) push_op(i);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          fpu_ready = pat[k % 4];
          tick();
        end
        fpu_ready = 1'b1;
      end
    join
    stall_en = 1'b0;
    wait_drain();
    check("t3_handshakes", 32'(hs_cnt - hs0), 32'h4);

    // Test 4: spurious result
    repeat (3) tick();
    check("t4_idle", 32'(outstanding), 32'h0);
    spur_d = 32'hDEADBEEF;
    spur_v = 1'b1;
    tick();
    spur_v = 1'b0;
    check("t4_err", 32'(err_spurious), 32'h1);
    check("t4_res_valid", 32'(res_valid), 32'h0);
    repeat (3) tick();
    check("t4_err_sticky", 32'(err_spurious), 32'h1);
    check("t4_res_valid_later", 32'(res_valid), 32'h0);

    // Test 5: reset mid-operation
    for (int i = 5; i < 9; i++) push_op(i % 8);
    n = 0;
    while (outstanding != CW'(2) && n < 20) begin
      tick();
      n++;
    end
    check("t5_outstanding_pre", 32'(outstanding), 32'h2);
    check("t5_fpu_valid_pre", 32'(fpu_valid), 32'h1);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs("t5");
    tick();
    rst = 1'b1;
    check("t5_credits", 32'(dut.credits_q), 32'h4);
    repeat (5) tick();
    check("t5_no_err", 32'(err_spurious), 32'h0);
    check("t5_res_valid", 32'(res_valid), 32'h0);

    // Test 6: streaming with a latency-1 multiplier
    lat = 1;
    fpu_ready = 1'b1;
    res_ready = 1'b1;
    p0 = 0;
    op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op_a = vec_op[i % 8].a;
      op_b = vec_op[i % 8].b;
      check("t6_op_ready", 32'(op_ready), 32'h1);
      sb_q.push_back(vec_p[i % 8]);
      if (i == 8) p0 = pop_cnt;
      tick();
    end
    p1 = pop_cnt;
    op_valid = 1'b0;
    check("t6_throughput", 32'(p1 - p0), 32'd12);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
